// File: rtl/sram_arb_pkg.sv
// Shared IDs, size codes and FSM encodings for the SRAM port arbiter.
// Optional round-robin priority is enabled with SRAM_ARB_RR_EN.
package sram_arb_pkg;

  typedef logic req_id_t;

  localparam req_id_t REQ_INST = 1'b0;
  localparam req_id_t REQ_DATA = 1'b1;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [1:0] ARB    = 2'd0;
  localparam logic [1:0] HOLD_I = 2'd1;
  localparam logic [1:0] HOLD_D = 2'd2;

endpackage

// File: rtl/sram_arb_idq.sv
// In-order owner FIFO for accepted memory requests.
// Extra pointer MSB tells full from empty.
module sram_arb_idq
  import sram_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  logic    pop,
  input  req_id_t din,
  output req_id_t head,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  req_id_t       ent_q [DEPTH];
  req_id_t       ent_d [DEPTH];

  always_comb begin
    wp_d  = wp_q + PW'(push);
    rp_d  = rp_q + PW'(pop);
    ent_d = ent_q;
    if (push) ent_d[wp_q[AW-1:0]] = din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      ent_q <= '{default: REQ_INST};
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      ent_q <= ent_d;
    end
  end

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW] != rp_q[AW]) &&
                 (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign head  = ent_q[rp_q[AW-1:0]];

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like port between fetch and load/store requesters.
// SRAM_ARB_RR_EN selects round-robin instead of data-first priority.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int OUTSTANDING = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W/8-1:0] inst_wstrb,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              arb_err
);

  logic [1:0] state_q, state_d;
  logic       arb_err_q, arb_err_d;
  logic       gnt_v;
  req_id_t    gnt_id;
  req_id_t    tie_pick;
  req_id_t    head;
  logic       full, empty, push, pop;

`ifdef SRAM_ARB_RR_EN
  req_id_t last_q, last_d;

  // Tie goes to whoever lost the previous arbitration.
  assign tie_pick = ~last_q;

  always_comb begin
    last_d = last_q;
    if (state_q == ARB && push) last_d = gnt_id;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) last_q <= REQ_INST;
    else         last_q <= last_d;
  end
`else
  assign tie_pick = REQ_DATA;
`endif

  always_comb begin
    gnt_v  = 1'b0;
    gnt_id = REQ_INST;
    case (state_q)
      ARB: begin
        if (!full) begin
          if (inst_req && data_req) begin
            gnt_v  = 1'b1;
            gnt_id = tie_pick;
          end else if (data_req) begin
            gnt_v  = 1'b1;
            gnt_id = REQ_DATA;
          end else if (inst_req) begin
            gnt_v  = 1'b1;
            gnt_id = REQ_INST;
          end
        end
      end
      HOLD_I: begin
        gnt_v  = inst_req;
        gnt_id = REQ_INST;
      end
      HOLD_D: begin
        gnt_v  = data_req;
        gnt_id = REQ_DATA;
      end
      default: ;
    endcase
    // Reset must silence the port before any clock edge.
    if (!resetn) gnt_v = 1'b0;
  end

  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = '0;
    mem_addr  = '0;
    mem_wstrb = '0;
    mem_wdata = '0;
    if (gnt_v) begin
      if (gnt_id == REQ_DATA) begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_addr  = data_addr;
        mem_wstrb = data_wstrb;
        mem_wdata = data_wdata;
      end else begin
        mem_wr    = inst_wr;
        mem_size  = inst_size;
        mem_addr  = inst_addr;
        mem_wstrb = inst_wstrb;
        mem_wdata = inst_wdata;
      end
    end
  end

  assign mem_req      = gnt_v;
  assign push         = gnt_v & mem_addr_ok;
  assign inst_addr_ok = push & (gnt_id == REQ_INST);
  assign data_addr_ok = push & (gnt_id == REQ_DATA);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB: begin
        if (gnt_v && !mem_addr_ok)
          state_d = (gnt_id == REQ_DATA) ? HOLD_D : HOLD_I;
      end
      HOLD_I, HOLD_D: begin
        if (push) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  assign pop          = mem_data_ok & ~empty;
  assign inst_data_ok = pop & (head == REQ_INST);
  assign data_data_ok = pop & (head == REQ_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign arb_err_d    = arb_err_q | (mem_data_ok & empty);
  assign arb_err      = arb_err_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ARB;
      arb_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      arb_err_q <= arb_err_d;
    end
  end

  sram_arb_idq #(
    .DEPTH(OUTSTANDING)
  ) u_idq (
    .clk  (clk),
    .rst_n(resetn),
    .push (push),
    .pop  (pop),
    .din  (gnt_id),
    .head (head),
    .full (full),
    .empty(empty)
  );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized scoreboard bench for sram_port_arbiter.
// Define SRAM_ARB_RR_EN to check round-robin priority.
module tb_sram_port_arbiter;

  localparam int OUT = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic          inst_req = 0, inst_wr = 0;
  logic [1:0]    inst_size = 0;
  logic [AW-1:0] inst_addr = 0;
  logic [3:0]    inst_wstrb = 0;
  logic [DW-1:0] inst_wdata = 0;
  logic          data_req = 0, data_wr = 0;
  logic [1:0]    data_size = 0;
  logic [AW-1:0] data_addr = 0;
  logic [3:0]    data_wstrb = 0;
  logic [DW-1:0] data_wdata = 0;
  logic          mem_addr_ok = 0, mem_data_ok = 0;
  logic [DW-1:0] mem_rdata = 0;

  logic          inst_addr_ok, inst_data_ok;
  logic [DW-1:0] inst_rdata;
  logic          data_addr_ok, data_data_ok;
  logic [DW-1:0] data_rdata;
  logic          mem_req, mem_wr;
  logic [1:0]    mem_size;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_wstrb;
  logic [DW-1:0] mem_wdata;
  logic          arb_err;

  sram_port_arbiter #(
    .OUTSTANDING(OUT),
    .ADDR_W     (AW),
    .DATA_W     (DW)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .inst_req    (inst_req),
    .inst_wr     (inst_wr),
    .inst_size   (inst_size),
    .inst_addr   (inst_addr),
    .inst_wstrb  (inst_wstrb),
    .inst_wdata  (inst_wdata),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata  (inst_rdata),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_size   (data_size),
    .data_addr   (data_addr),
    .data_wstrb  (data_wstrb),
    .data_wdata  (data_wdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata  (data_rdata),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_size    (mem_size),
    .mem_addr    (mem_addr),
    .mem_wstrb   (mem_wstrb),
    .mem_wdata   (mem_wdata),
    .mem_addr_ok (mem_addr_ok),
    .mem_data_ok (mem_data_ok),
    .mem_rdata   (mem_rdata),
    .arb_err     (arb_err)
  );

  typedef struct {
    bit          own;
    logic [31:0] rd;
  } rsp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  rsp_t sb[$];
  bit   own_q[$];
  int   cnt = 0;
  int   held = -1;
  int   last = 0;
  bit   err_m = 0;
  int   acc_id = -1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model predicts the grant from the rules.
  task automatic cycle(bit ir, bit dr, bit aok, bit dok,
                       logic [31:0] rd);
    int win;
    @(posedge clk);
    #1;
    inst_req    = ir;
    data_req    = dr;
    mem_addr_ok = aok;
    mem_data_ok = dok;
    mem_rdata   = rd;
    #1;
    if (held >= 0)
      win = ((held == 1) ? dr : ir) ? held : -1;
    else if (cnt >= OUT)
      win = -1;
    else if (ir && dr) begin
`ifdef SRAM_ARB_RR_EN
      win = (last == 0) ? 1 : 0;
`else
      win = 1;
`endif
    end else if (dr) win = 1;
    else if (ir)     win = 0;
    else             win = -1;

    chk("mem_req", mem_req, win >= 0);
    chk("inst_addr_ok", inst_addr_ok, win == 0 && aok);
    chk("data_addr_ok", data_addr_ok, win == 1 && aok);
    chk("arb_err", arb_err, err_m);
    if (win == 1) begin
      chk("mem_addr_d", mem_addr, data_addr);
      chk("mem_wr_d", mem_wr, data_wr);
      chk("mem_size_d", mem_size, data_size);
      chk("mem_wstrb_d", mem_wstrb, data_wstrb);
      chk("mem_wdata_d", mem_wdata, data_wdata);
    end else if (win == 0) begin
      chk("mem_addr_i", mem_addr, inst_addr);
      chk("mem_wr_i", mem_wr, inst_wr);
      chk("mem_size_i", mem_size, inst_size);
    end

    acc_id = (win >= 0 && aok) ? win : -1;
    if (dok) begin
      if (own_q.size() > 0) begin
        sb.push_back('{own: own_q.pop_front(), rd: rd});
        cnt--;
      end else begin
        err_m = 1;
      end
    end
    if (acc_id >= 0) begin
      own_q.push_back(acc_id[0]);
      cnt++;
      if (held < 0) last = acc_id;
      held = -1;
    end else if (win >= 0 && held < 0) begin
      held = win;
    end
  endtask

  // Response monitor, decoupled from the stimulus.
  always @(negedge clk) begin
    rsp_t r;
    if (resetn) begin
      if (inst_data_ok && data_data_ok) begin
        n_cmp++;
        n_bad++;
        $display("FAIL both_data_ok at %0t", $time);
        if (sb.size() > 0) void'(sb.pop_front());
      end else if (inst_data_ok || data_data_ok) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_data_ok: inst %0b data %0b",
                   inst_data_ok, data_data_ok);
        end else begin
          r = sb.pop_front();
          chk("rsp_owner", data_data_ok, r.own);
          chk("rsp_rdata", data_data_ok ? data_rdata : inst_rdata, r.rd);
        end
      end else if (sb.size() > 0) begin
        r = sb.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missing_data_ok: got none want owner %0b", r.own);
      end
    end
  end

  task automatic model_reset();
    cnt  = 0;
    held = -1;
    last = 0;
    err_m = 0;
    own_q.delete();
    sb.delete();
  endtask

  initial begin
    bit ip, dp, aok, dok;
    #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_inst_addr_ok", inst_addr_ok, 0);
    chk("rst_data_addr_ok", data_addr_ok, 0);
    chk("rst_inst_data_ok", inst_data_ok, 0);
    chk("rst_data_data_ok", data_data_ok, 0);
    chk("rst_arb_err", arb_err, 0);
    chk("rst_mem_addr", mem_addr, 0);
    @(posedge clk);
    #3 resetn = 1;

    inst_addr = 32'h1c00_0000;
    data_addr = 32'h1c00_0100;
    data_size = 2'd2;
    inst_size = 2'd2;
    // simultaneous requests
    cycle(1, 1, 1, 0, 0);
    cycle(1, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 32'h1111_0001);
    cycle(0, 0, 0, 1, 32'h2222_0002);
    // routing inst then data
    cycle(1, 0, 1, 0, 0);
    cycle(0, 1, 1, 0, 0);
    cycle(0, 0, 0, 1, 32'hAAAA_0001);
    cycle(0, 0, 0, 1, 32'hBBBB_0002);
    // hold stability, then full queue
    inst_addr = 32'h1c00_0040;
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 1, 0, 0);
    cycle(0, 1, 1, 0, 0);
    cycle(1, 1, 1, 0, 0);
    cycle(1, 1, 1, 1, 32'h3333_0003);
    cycle(1, 1, 1, 0, 0);
    cycle(0, 0, 0, 1, 32'h4444_0004);
    cycle(0, 0, 0, 1, 32'h5555_0005);
    cycle(0, 0, 0, 0, 0);
    // error on empty queue, then async reset mid HOLD_D
    cycle(0, 0, 0, 1, 32'hdead_0000);
    cycle(0, 1, 0, 0, 0);
    #1 resetn = 0;
    #1;
    chk("async_mem_req", mem_req, 0);
    chk("async_data_addr_ok", data_addr_ok, 0);
    chk("async_arb_err", arb_err, 0);
    model_reset();
    data_req = 0;
    @(posedge clk);
    #3 resetn = 1;
    cycle(0, 0, 0, 1, 32'h6666_0006);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // reset again to clear the error for the random phase
    @(posedge clk);
    #3 resetn = 0;
    model_reset();
    @(posedge clk);
    #3 resetn = 1;

`ifdef SRAM_ARB_RR_EN
    for (int i = 0; i < 8; i++)
      cycle(1, 1, 1, own_q.size() > 0, $urandom);
    while (own_q.size() > 0) cycle(0, 0, 0, 1, $urandom);
`endif

    ip = 0;
    dp = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!ip && $urandom_range(0, 2) != 0) begin
        ip = 1;
        inst_addr = $urandom;
        inst_size = 2'($urandom_range(0, 2));
        inst_wr   = 1'b0;
      end
      if (!dp && $urandom_range(0, 2) != 0) begin
        dp = 1;
        data_addr  = $urandom;
        data_wr    = 1'($urandom_range(0, 1));
        data_size  = 2'($urandom_range(0, 2));
        data_wstrb = 4'($urandom);
        data_wdata = $urandom;
      end
      aok = 1'($urandom_range(0, 1));
      dok = (own_q.size() > 0) && ($urandom_range(0, 2) != 0);
      cycle(ip, dp, aok, dok, $urandom);
      if (acc_id == 0) ip = 0;
      if (acc_id == 1) dp = 0;
    end
    for (int i = 0; i < 20 && own_q.size() > 0; i++)
      cycle(ip, dp, 0, 1, $urandom);
    cycle(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
